mmu_seq: RTL
============

# mmu_seq

Sequencer for the 3x3 weight-stationary systolic MMU. It takes a start request, pops three weight rows from the weight FIFO, and drives the staggered per-column capture enables so the weights land in the PEs. It then streams `num_vec` activation vectors from the unified buffer and flags when each column's accumulator output is valid. It sits between the top-level command decoder and the MMU, weight FIFO, UB read port and accumulator.

## Interface
Parameters:
- `ARRAY_SIZE`, 3: array dimension; only 3 is supported.
- `CNT_WIDTH`, 8: width of the vector count and UB address.
- `PIPE_LAT`, 4: cycles from `ub_rd_en` to the column-0 result at the MMU output (1 UB read + 3 row stages).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin an operation; sampled only in IDLE.
- `skip_wload` in 1: reuse resident weights; sampled with `start`.
- `num_vec` in CNT_WIDTH: activation vector count; sampled with `start`.
- `ub_base` in CNT_WIDTH: first UB address; sampled with `start`.
- `wf_empty` in 1: weight FIFO empty.
- `wf_rd_en` out 1: weight FIFO pop.
- `ub_rd_en` out 1: UB read strobe.
- `ub_addr` out CNT_WIDTH: UB read address.
- `en_weight_pass` out 1: MMU psum-path pass enable.
- `en_capture_col0`, `en_capture_col1`, `en_capture_col2` out 1 each: per-column weight capture.
- `acc_valid` out 3: bit j set means column j accumulator output is valid this cycle.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `perf_busy_cycles` out 32: performance counter (see Configuration).
- `perf_stall_cycles` out 32: performance counter (see Configuration).

## Operation
- The block has five states: IDLE, LOAD_W, COMPUTE, DRAIN and DONE.
- **IDLE**
  - On `start`, the block latches `num_vec`, `ub_base` and `skip_wload`.
  - It moves to LOAD_W, or to COMPUTE if `skip_wload` is set.
  - `start` outside IDLE is ignored.
- **LOAD_W** uses a load counter `wcnt` running 0..5.
  - `en_weight_pass` is 1 in every non-stalled LOAD_W cycle.
  - `wf_rd_en` is 1 at `wcnt` 0, 1 and 2. Rows pop bottom-first: row 2, then 1, then 0.
  - Stall: if `wf_empty` is 1 when `wcnt` < 3, then `wcnt` holds, and `wf_rd_en` and `en_weight_pass` are both 0.
  - `en_capture_col0` asserts at `wcnt`=3, `col1` at 4 and `col2` at 5. Each is a one-cycle pulse and no stall is possible at these counts.
  - After `wcnt`=5 the block goes to COMPUTE, or to DONE if `num_vec`=0.
- **COMPUTE**
  - `ub_rd_en`=1 for exactly `num_vec` consecutive cycles.
  - `ub_addr` = `ub_base` + i for i = 0..`num_vec`-1, wrapping modulo 2^CNT_WIDTH.
  - `num_vec`=0 with `skip_wload`=1 goes straight from IDLE to DONE.
- **DRAIN** waits PIPE_LAT+ARRAY_SIZE-1 cycles after the last `ub_rd_en`, then moves to DONE.
- **DONE** holds for one cycle with `done`=1, then returns to IDLE.
- **acc_valid**
  - Bit j is 1 for `num_vec` consecutive cycles, starting PIPE_LAT+j cycles after the first `ub_rd_en`.
  - It is generated by a per-column delayed copy of `ub_rd_en`, so it is independent of state.
- **busy** is 1 in every state except IDLE.
- **Reset** (asynchronous, at any point mid-operation): state returns to IDLE and all outputs and counters clear to 0. The counters are `wcnt`, the vector count, the drain count and the `acc_valid` delay line.

## Timing
- `start` sampled at edge T: `busy`=1 and the first LOAD_W cycle begin at T+1.
- The weight load with no stalls takes 6 cycles, and the first `ub_rd_en` follows at T+7.
- With `skip_wload`=1, the first `ub_rd_en` is at T+1.
- `done` is pulsed in the cycle immediately after DRAIN ends, i.e. after the last `acc_valid[2]` cycle.
- `busy` falls in the cycle after `done`.
- Total duration with no stalls:
  - 6 + `num_vec` + PIPE_LAT + 2 + 1 cycles from T+1.
  - `num_vec`=4: cycles T+1..T+17, with `done` at T+17.
- A new `start` is accepted in the first IDLE cycle after `done`.
- All outputs are registered.

## Configuration
- `MMU_SEQ_PERF_EN` defined:
  - `perf_busy_cycles` increments every cycle in which `busy`=1.
  - `perf_stall_cycles` increments every LOAD_W stall cycle.
  - Both counters saturate at 2^32-1 and clear only on reset.
- `MMU_SEQ_PERF_EN` undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Reset with `start`=1 held: all outputs are 0. After release, `start` with `num_vec`=4, `ub_base`=0x10 and a non-empty FIFO gives:
  - `wf_rd_en` at T+1..T+3;
  - captures for col0/col1/col2 at T+4, T+5 and T+6;
  - `ub_addr` 0x10..0x13 at T+7..T+10;
  - `acc_valid[0]` at T+11..T+14 and `acc_valid[2]` at T+13..T+16;
  - `done` at T+17.
- `wf_empty`=1 for 3 cycles at `wcnt`=1 → `wcnt` holds, `wf_rd_en` and `en_weight_pass` are 0 for those 3 cycles, `done` moves to T+20, and `perf_stall_cycles`=3 when `MMU_SEQ_PERF_EN` is defined.
- `skip_wload`=1 with `num_vec`=2 → no `wf_rd_en` and no capture pulses, `ub_rd_en` at T+1..T+2, `done` at T+9.
- `ub_base`=0xFE with `num_vec`=3 → addresses 0xFE, 0xFF, 0x00. `num_vec`=0 with `skip_wload`=0 → 6-cycle load then `done` at T+7, with no `ub_rd_en` and no `acc_valid`.
- `start` pulsed mid-COMPUTE is ignored. Asserting `rst_n`=0 mid-DRAIN → `busy`, `done` and `acc_valid` all read 0 immediately, and a fresh `start` after reset behaves as in the first scenario.

Source files
------------

// File: rtl/mmu_seq.sv
// Weight-load / activation-stream sequencer for the 3x3 weight-stationary MMU.
// Optional perf counters are built only when MMU_SEQ_PERF_EN is defined.
module mmu_seq #(
  parameter int ARRAY_SIZE = 3,
  parameter int CNT_WIDTH  = 8,
  parameter int PIPE_LAT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  skip_wload,
  input  logic [CNT_WIDTH-1:0]  num_vec,
  input  logic [CNT_WIDTH-1:0]  ub_base,
  input  logic                  wf_empty,
  output logic                  wf_rd_en,
  output logic                  ub_rd_en,
  output logic [CNT_WIDTH-1:0]  ub_addr,
  output logic                  en_weight_pass,
  output logic                  en_capture_col0,
  output logic                  en_capture_col1,
  output logic                  en_capture_col2,
  output logic [ARRAY_SIZE-1:0] acc_valid,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_stall_cycles
);

  localparam int STAGES = PIPE_LAT + ARRAY_SIZE - 1;
  localparam int DW     = (STAGES > 2) ? $clog2(STAGES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0]  vcnt_q, vcnt_d;
  logic [DW-1:0]         dcnt_q, dcnt_d;
  logic [CNT_WIDTH-1:0]  nv_q, nv_d;
  logic [CNT_WIDTH-1:0]  base_q, base_d;
  logic                  stall_q, stall_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wf_rd_en_q, wf_rd_en_d;
  logic                  pass_q, pass_d;
  logic [ARRAY_SIZE-1:0] cap_q, cap_d;
  logic                  ub_rd_en_q, ub_rd_en_d;
  logic [CNT_WIDTH-1:0]  ub_addr_q, ub_addr_d;
  logic [STAGES:1]       vld_pipe_q;

  // Outputs are registered from the next-cycle state, so every output
  // describes the cycle the state register is about to enter.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    vcnt_d  = vcnt_q;
    dcnt_d  = dcnt_q;
    nv_d    = nv_q;
    base_d  = base_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nv_d   = num_vec;
          base_d = ub_base;
          wcnt_d = '0;
          vcnt_d = '0;
          dcnt_d = '0;
          if (!skip_wload)                 state_d = S_LOAD_W;
          else if (num_vec == '0)          state_d = S_DONE;
          else                             state_d = S_COMPUTE;
        end
      end
      S_LOAD_W: begin
        if (!stall_q) begin
          if (wcnt_q == 3'd5) begin
            wcnt_d  = '0;
            state_d = (nv_q == '0) ? S_DONE : S_COMPUTE;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end
      end
      S_COMPUTE: begin
        if (vcnt_q == nv_q - CNT_WIDTH'(1)) begin
          vcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          vcnt_d = vcnt_q + CNT_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DW'(STAGES - 1)) begin
          dcnt_d  = '0;
          state_d = S_DONE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An empty FIFO only matters while rows are still being popped.
    stall_d    = (state_d == S_LOAD_W) && (wcnt_d < 3'd3) && wf_empty;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    wf_rd_en_d = (state_d == S_LOAD_W) && (wcnt_d < 3'd3) && !stall_d;
    pass_d     = (state_d == S_LOAD_W) && !stall_d;
    for (int j = 0; j < ARRAY_SIZE; j++)
      cap_d[j] = (state_d == S_LOAD_W) && (wcnt_d == 3'(3 + j));
    ub_rd_en_d = (state_d == S_COMPUTE);
    ub_addr_d  = (state_d == S_COMPUTE) ? base_d + vcnt_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      vcnt_q     <= '0;
      dcnt_q     <= '0;
      nv_q       <= '0;
      base_q     <= '0;
      stall_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wf_rd_en_q <= 1'b0;
      pass_q     <= 1'b0;
      cap_q      <= '0;
      ub_rd_en_q <= 1'b0;
      ub_addr_q  <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      vcnt_q     <= vcnt_d;
      dcnt_q     <= dcnt_d;
      nv_q       <= nv_d;
      base_q     <= base_d;
      stall_q    <= stall_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wf_rd_en_q <= wf_rd_en_d;
      pass_q     <= pass_d;
      cap_q      <= cap_d;
      ub_rd_en_q <= ub_rd_en_d;
      ub_addr_q  <= ub_addr_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], ub_rd_en_q};
    end
  end

  // vld_pipe_q[k] is ub_rd_en delayed k cycles; column j taps PIPE_LAT+j.
  for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
    assign acc_valid[j] = vld_pipe_q[PIPE_LAT + j];
  end

  assign wf_rd_en        = wf_rd_en_q;
  assign ub_rd_en        = ub_rd_en_q;
  assign ub_addr         = ub_addr_q;
  assign en_weight_pass  = pass_q;
  assign en_capture_col0 = cap_q[0];
  assign en_capture_col1 = cap_q[1];
  assign en_capture_col2 = cap_q[2];
  assign busy            = busy_q;
  assign done            = done_q;

`ifdef MMU_SEQ_PERF_EN
  logic [31:0] pbusy_q, pbusy_d;
  logic [31:0] pstall_q, pstall_d;

  always_comb begin
    pbusy_d  = pbusy_q;
    pstall_d = pstall_q;
    if (busy_q && (pbusy_q != '1))   pbusy_d  = pbusy_q + 32'd1;
    if (stall_q && (pstall_q != '1)) pstall_d = pstall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else begin
      pbusy_q  <= pbusy_d;
      pstall_q <= pstall_d;
    end
  end

  assign perf_busy_cycles  = pbusy_q;
  assign perf_stall_cycles = pstall_q;
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule
